// File: rtl/word_narrower.sv
// word_narrower: registered 32-to-16-bit down-converter.
// Accepts 32-bit words over valid/ready and emits 16-bit beats, low half
// first. With COMPRESS=1, a word whose upper half is zero goes out as a
// single beat flagged out_zext, and the receiver restores bits [31:16]=0.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   in_data holds a word to transfer
//   in_ready   block can accept a word this cycle (combinational)
//   in_data    32-bit word to narrow
//   out_valid  out_data holds a beat
//   out_ready  consumer takes the beat this cycle
//   out_data   current 16-bit beat
//   out_zext   single-beat word, upper half is zero
//   out_last   final beat of the current word
//   zext_count number of words sent compressed, wraps modulo 2^16
module word_narrower #(
    parameter bit COMPRESS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_zext,
    output logic        out_last,
    output logic [15:0] zext_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] word_q;
    logic [15:0] out_data_q;
    logic        out_zext_q;
    logic        out_last_q;
    logic [15:0] zext_count_q;

    logic in_xfer;
    logic out_xfer;
    logic zx;

    // A new word may be taken in the same cycle the final beat leaves,
    // so back-to-back single-beat words stream at one per cycle.
    assign in_ready = (state_q == IDLE) || (out_ready && out_last_q);
    assign out_valid = (state_q != IDLE);

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign zx       = COMPRESS && (in_data[31:16] == 16'h0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            word_q       <= '0;
            out_data_q   <= '0;
            out_zext_q   <= 1'b0;
            out_last_q   <= 1'b0;
            zext_count_q <= '0;
        end else begin
            if (out_xfer && out_zext_q) begin
                zext_count_q <= zext_count_q + 16'd1;
            end

            // in_xfer outside IDLE implies the final beat is leaving now,
            // so loading takes priority over the out_last=1 retire path.
            if (in_xfer) begin
                state_q    <= LOW;
                word_q     <= in_data;
                out_data_q <= in_data[15:0];
                out_zext_q <= zx;
                out_last_q <= zx;
            end else if (out_xfer) begin
                if (out_last_q) begin
                    state_q <= IDLE;
                end else begin
                    state_q    <= HIGH;
                    out_data_q <= word_q[31:16];
                    out_zext_q <= 1'b0;
                    out_last_q <= 1'b1;
                end
            end
        end
    end

    assign out_data   = out_data_q;
    assign out_zext   = out_zext_q;
    assign out_last   = out_last_q;
    assign zext_count = zext_count_q;

endmodule

// File: tb/tb_word_narrower.sv
module tb_word_narrower;

    logic        clk;
    logic        reset;

    // Stimulus and observation for the COMPRESS=1 instance.
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_zext;
    logic        out_last;
    logic [15:0] zext_count;

    // Stimulus and observation for the COMPRESS=0 instance.
    logic        c_in_valid;
    logic        c_in_ready;
    logic [31:0] c_in_data;
    logic        c_out_valid;
    logic        c_out_ready;
    logic [15:0] c_out_data;
    logic        c_out_zext;
    logic        c_out_last;
    logic [15:0] c_zext_count;

    int checks = 0;
    int errors = 0;

    word_narrower #(.COMPRESS(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_zext   (out_zext),
        .out_last   (out_last),
        .zext_count (zext_count)
    );

    word_narrower #(.COMPRESS(1'b0)) dut_nc (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (c_in_valid),
        .in_ready   (c_in_ready),
        .in_data    (c_in_data),
        .out_valid  (c_out_valid),
        .out_ready  (c_out_ready),
        .out_data   (c_out_data),
        .out_zext   (c_out_zext),
        .out_last   (c_out_last),
        .zext_count (c_zext_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs
    // sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        c_in_valid  = 1'b0;
        c_in_data   = '0;
        c_out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state.
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'h0);
        check_eq("rst_zext", 32'(out_zext), 32'd0);
        check_eq("rst_last", 32'(out_last), 32'd0);
        check_eq("rst_count", 32'(zext_count), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // Full word: two beats, low half first.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h1234_ABCD;
        step();
        in_valid = 1'b0;
        check_eq("full_lo_valid", 32'(out_valid), 32'd1);
        check_eq("full_lo_data", 32'(out_data), 32'hABCD);
        check_eq("full_lo_zext", 32'(out_zext), 32'd0);
        check_eq("full_lo_last", 32'(out_last), 32'd0);
        check_eq("full_lo_in_ready", 32'(in_ready), 32'd0);
        step();
        check_eq("full_hi_data", 32'(out_data), 32'h1234);
        check_eq("full_hi_zext", 32'(out_zext), 32'd0);
        check_eq("full_hi_last", 32'(out_last), 32'd1);
        step();
        check_eq("full_done_valid", 32'(out_valid), 32'd0);
        check_eq("full_done_count", 32'(zext_count), 32'd0);

        // Compressible word: one zext beat.
        in_valid = 1'b1;
        in_data  = 32'h0000_00FF;
        step();
        in_valid = 1'b0;
        check_eq("cmp_data", 32'(out_data), 32'h00FF);
        check_eq("cmp_zext", 32'(out_zext), 32'd1);
        check_eq("cmp_last", 32'(out_last), 32'd1);
        check_eq("cmp_in_ready", 32'(in_ready), 32'd1);
        step();
        check_eq("cmp_done_valid", 32'(out_valid), 32'd0);
        check_eq("cmp_count", 32'(zext_count), 32'd1);

        // Same word through the COMPRESS=0 instance: two beats, no zext.
        c_out_ready = 1'b1;
        c_in_valid  = 1'b1;
        c_in_data   = 32'h0000_00FF;
        step();
        c_in_valid = 1'b0;
        check_eq("nc_lo_data", 32'(c_out_data), 32'h00FF);
        check_eq("nc_lo_zext", 32'(c_out_zext), 32'd0);
        check_eq("nc_lo_last", 32'(c_out_last), 32'd0);
        step();
        check_eq("nc_hi_data", 32'(c_out_data), 32'h0000);
        check_eq("nc_hi_zext", 32'(c_out_zext), 32'd0);
        check_eq("nc_hi_last", 32'(c_out_last), 32'd1);
        step();
        check_eq("nc_done_valid", 32'(c_out_valid), 32'd0);
        check_eq("nc_count", 32'(c_zext_count), 32'd0);

        // Back-to-back compressed words, one per cycle.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        step();
        check_eq("b2b1_data", 32'(out_data), 32'h1);
        check_eq("b2b1_last", 32'(out_last), 32'd1);
        check_eq("b2b1_in_ready", 32'(in_ready), 32'd1);
        in_data = 32'h2;
        step();
        check_eq("b2b2_data", 32'(out_data), 32'h2);
        check_eq("b2b2_in_ready", 32'(in_ready), 32'd1);
        check_eq("b2b2_count", 32'(zext_count), 32'd1);
        in_data = 32'h3;
        step();
        check_eq("b2b3_data", 32'(out_data), 32'h3);
        check_eq("b2b3_zext", 32'(out_zext), 32'd1);
        check_eq("b2b3_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        step();
        check_eq("b2b_done_valid", 32'(out_valid), 32'd0);
        check_eq("b2b_count", 32'(zext_count), 32'd3);

        // Backpressure: beat held stable, stray input ignored.
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        step();
        in_data = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_data", 32'(out_data), 32'hBEEF);
            check_eq("stall_last", 32'(out_last), 32'd0);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("release_in_ready", 32'(in_ready), 32'd0);
        step();
        check_eq("release_hi_data", 32'(out_data), 32'hDEAD);
        check_eq("release_hi_last", 32'(out_last), 32'd1);
        check_eq("release_hi_zext", 32'(out_zext), 32'd0);
        step();
        check_eq("release_done_valid", 32'(out_valid), 32'd0);

        // Reset while the high beat is pending.
        in_valid = 1'b1;
        in_data  = 32'h1234_ABCD;
        step();
        in_valid = 1'b0;
        step();
        check_eq("prerst_data", 32'(out_data), 32'h1234);
        check_eq("prerst_last", 32'(out_last), 32'd1);
        out_ready = 1'b0;
        do_reset();
        check_eq("midrst_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_data", 32'(out_data), 32'h0);
        check_eq("midrst_last", 32'(out_last), 32'd0);
        check_eq("midrst_count", 32'(zext_count), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        step();
        check_eq("midrst_hold_valid", 32'(out_valid), 32'd0);

        // Counter wrap: 65536 compressed words, then one more.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_data = {16'h0000, 16'(i)};
            step();
        end
        in_valid = 1'b0;
        check_eq("wrap_pre_count", 32'(zext_count), 32'hFFFF);
        check_eq("wrap_pre_data", 32'(out_data), 32'hFFFF);
        step();
        check_eq("wrap_count", 32'(zext_count), 32'h0000);
        check_eq("wrap_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'h0000_0000;
        step();
        in_valid = 1'b0;
        check_eq("zero_word_data", 32'(out_data), 32'h0);
        check_eq("zero_word_zext", 32'(out_zext), 32'd1);
        check_eq("zero_word_last", 32'(out_last), 32'd1);
        step();
        check_eq("wrap_next_count", 32'(zext_count), 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
